seven_sd_pattern_setter: RTL and testbench
==========================================

SEVEN_SD_PATTERN_SETTER -- requirements
Module: seven_sd_pattern_setter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles required to accept a button level.
REQ-002 SHALL have parameter BLINK_CYCLES, default 25000000, cycles per decimal-point blink phase.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port btn_next, input, 1, asynchronous button that advances the selected digit.
REQ-006 SHALL have port btn_inc, input, 1, asynchronous button that increments the selected digit.
REQ-007 SHALL have port btn_dec, input, 1, asynchronous button that decrements the selected digit.
REQ-008 SHALL have port signals, output, 32, registered active-low segment patterns; byte i (bits 8i+7:8i) is digit i; per byte bit0..6 = segments a..g, bit7 = dp.
REQ-009 SHALL have port sel_digit, output, 2, index of the currently selected digit.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Per button, a debounce counter SHALL clear whenever the synchronized level equals the debounced level, and otherwise increment.
REQ-012 The debounced level SHALL take the synchronized value on the cycle the counter reaches DEBOUNCE_CYCLES-1; the counter SHALL then clear.
REQ-013 A one-cycle pulse SHALL be generated on each 0->1 transition of a debounced level; 1->0 transitions SHALL generate no pulse.
REQ-014 The block SHALL hold four 4-bit hex values; an inc pulse SHALL add 1 mod 16 (F->0) to the selected digit; a dec pulse SHALL subtract 1 mod 16 (0->F).
REQ-015 If inc and dec pulses occur in the same cycle, the digit SHALL be left unchanged.
REQ-016 A next pulse SHALL advance sel_digit by 1 mod 4 (3->0).
REQ-017 If next and inc/dec pulse together, the edit SHALL apply to the pre-advance digit and the selection SHALL then advance, both in the same cycle.
REQ-018 The blink counter SHALL count 0..BLINK_CYCLES-1 and wrap; blink_phase SHALL toggle at the wrap.
REQ-019 Any next/inc/dec pulse SHALL clear the blink counter and set blink_phase to 1.
REQ-020 Each byte SHALL use the standard active-low hex font: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-021 The dp bit SHALL be 0 only for the selected digit while blink_phase=1; all other dp bits SHALL be 1.
REQ-022 signals SHALL reflect a value or selection change exactly one clk cycle after the cycle it occurs.

Reset
REQ-023 On rst assertion, all state SHALL clear immediately without waiting for clk: digits=0, sel_digit=0, blink counter=0, blink_phase=0, debounce counters=0, debounced levels=0, synchronizers=0, signals=32'hC0C0C0C0.
REQ-024 A button held high through reset release SHALL produce exactly one pulse, after DEBOUNCE_CYCLES stable cycles.
REQ-025 Reset asserted mid-debounce or mid-blink SHALL discard the partial count; no pulse SHALL be produced from pre-reset activity.

Verification (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8)
REQ-026 Reset -> signals=C0C0C0C0, sel_digit=0; after 8 idle cycles byte0 becomes 40, the other bytes remain C0.
REQ-027 btn_inc held high 10 cycles -> exactly one pulse; digit0=1; byte0=79 (dp lit) one cycle after the pulse.
REQ-028 btn_dec pulse at reset -> digit0=F, byte0=0E; btn_next four times -> sel_digit returns to 0.
REQ-029 btn_inc toggling with a period under 4 cycles for 40 cycles, then released low -> no pulse and signals unchanged.
REQ-030 btn_inc and btn_dec rising together -> digit unchanged; btn_next and btn_inc together with sel=3 -> digit3 incremented, sel_digit=0.
REQ-031 rst pulsed while btn_next is 2 cycles into debounce, button then released -> sel_digit stays 0 and no pulse is produced.

Source files
------------

// File: rtl/seven_sd_pattern_setter.sv
// Three-button hex pattern editor for a four-digit seven-segment display.
// Buttons are synchronized and debounced; the selected digit blinks its dp.
module seven_sd_pattern_setter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  output logic [31:0] signals,
  output logic [1:0]  sel_digit
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

  logic [2:0]    btn;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    db_q, db_d, dbp_q;
  logic [2:0]    pulse;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [3:0]    dig_q [4];
  logic [3:0]    dig_d [4];
  logic [1:0]    sel_q, sel_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [31:0]   sig_q, sig_d;
  logic [7:0]    seg;

  assign btn       = {btn_dec, btn_inc, btn_next};
  assign pulse     = db_q & ~dbp_q;
  assign signals   = sig_q;
  assign sel_digit = sel_q;

  function automatic logic [7:0] font(input logic [3:0] v);
    logic [7:0] f;
    case (v)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hA: f = 8'h88;
      4'hB: f = 8'h83;
      4'hC: f = 8'hC6;
      4'hD: f = 8'hA1;
      4'hE: f = 8'h86;
      default: f = 8'h8E;
    endcase
    return f;
  endfunction

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end

    // Edit lands on the pre-advance digit; selection moves in the same cycle
    for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];
    if (pulse[1] && !pulse[2]) dig_d[sel_q] = dig_q[sel_q] + 4'd1;
    else if (pulse[2] && !pulse[1]) dig_d[sel_q] = dig_q[sel_q] - 4'd1;
    sel_d = sel_q + {1'b0, pulse[0]};

    bcnt_d  = bcnt_q + BW'(1);
    phase_d = phase_q;
    if (|pulse) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == BL_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end

    sig_d = '0;
    seg   = '0;
    for (int i = 0; i < 4; i++) begin
      seg = font(dig_d[i]);
      if (phase_d && sel_d == 2'(i)) seg[7] = 1'b0;
      sig_d[8*i +: 8] = seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      for (int i = 0; i < 4; i++) dig_q[i] <= '0;
      sel_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      sig_q   <= 32'hC0C0C0C0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
      sel_q   <= sel_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      sig_q   <= sig_d;
    end
  end

endmodule

// File: tb/tb_seven_sd_pattern_setter.sv
// Randomized and directed bench for seven_sd_pattern_setter against a
// cycle-level behavioural model of buttons, digits and blink.
module tb_seven_sd_pattern_setter;

  localparam int D = 4;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic [31:0] signals;
  logic [1:0]  sel_digit;

  int vectors = 0;
  int miscompares = 0;

  seven_sd_pattern_setter #(
    .DEBOUNCE_CYCLES(D),
    .BLINK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_next(btn_next),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .signals(signals),
    .sel_digit(sel_digit)
  );

  always #5 clk = ~clk;

  bit [7:0] font_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
    8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // model state: 0=next 1=inc 2=dec
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_db [3];
  bit m_prev [3];
  int m_run [3];
  int m_dig [4];
  int m_sel;
  int m_bc;
  bit m_ph;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0;
      m_prev[i] = 0; m_run[i] = 0;
    end
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_sel = 0; m_bc = 0; m_ph = 0;
  endfunction

  function automatic void model_step(bit n, bit up, bit dn);
    bit p [3];
    bit in [3];
    in[0] = n; in[1] = up; in[2] = dn;
    for (int i = 0; i < 3; i++) p[i] = m_db[i] && !m_prev[i];
    if (p[1] && !p[2]) m_dig[m_sel] = (m_dig[m_sel] + 1) % 16;
    if (p[2] && !p[1]) m_dig[m_sel] = (m_dig[m_sel] + 15) % 16;
    if (p[0]) m_sel = (m_sel + 1) % 4;
    if (p[0] || p[1] || p[2]) begin
      m_bc = 0; m_ph = 1;
    end else if (m_bc == B - 1) begin
      m_bc = 0; m_ph = !m_ph;
    end else m_bc++;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = m_db[i];
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_db[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else m_run[i] = 0;
      m_s2[i] = m_s1[i];
      m_s1[i] = in[i];
    end
  endfunction

  function automatic logic [31:0] exp_sig();
    logic [31:0] r;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = font_tab[m_dig[i]];
      if (m_ph && m_sel == i) b[7] = 1'b0;
      r[8*i +: 8] = b;
    end
    return r;
  endfunction

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(btn_next, btn_inc, btn_dec);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    btn_inc = 1'b1;
    tick(12);
    btn_inc = 1'b0;
    tick(3);
    #1 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (signals !== 32'hC0C0C0C0 || sel_digit !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_async sig=%h sel=%0d req C0C0C0C0/0",
               signals, sel_digit);
    end
    @(negedge clk);
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_idle_blink();
    do_reset();
    tick(7);
    vectors++;
    if (signals !== 32'hC0C0C0C0) begin
      miscompares++;
      $display("FAIL idle7 sig=%h req C0C0C0C0", signals);
    end
    tick(1);
    vectors++;
    if (signals !== 32'hC0C0C040) begin
      miscompares++;
      $display("FAIL idle8 sig=%h req C0C0C040", signals);
    end
  endtask

  task automatic test_inc_hold();
    do_reset();
    btn_inc = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      vectors++;
      if (signals !== exp_sig()) begin
        miscompares++;
        $display("FAIL inc_hold c%0d sig=%h req %h", k, signals, exp_sig());
      end
    end
    vectors++;
    if (signals !== 32'hC0C0C079) begin
      miscompares++;
      $display("FAIL inc_hold_end sig=%h req C0C0C079", signals);
    end
    btn_inc = 1'b0;
    tick(20);
    vectors++;
    if (signals[6:0] !== 7'h79 || signals[31:8] !== 24'hC0C0C0) begin
      miscompares++;
      $display("FAIL inc_release sig=%h req byte0 x79", signals);
    end
  endtask

  task automatic press(int which, int hold, int gap);
    if (which == 0) btn_next = 1'b1;
    if (which == 1) btn_inc = 1'b1;
    if (which == 2) btn_dec = 1'b1;
    tick(hold);
    btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick(gap);
  endtask

  task automatic test_dec_next();
    do_reset();
    press(2, 8, 8);
    vectors++;
    if (signals[6:0] !== 7'h0E) begin
      miscompares++;
      $display("FAIL dec_wrap byte0=%h req x0E", signals[7:0]);
    end
    for (int k = 1; k <= 4; k++) begin
      press(0, 7, 7);
      vectors++;
      if (sel_digit !== 2'(k % 4) || signals !== exp_sig()) begin
        miscompares++;
        $display("FAIL next%0d sel=%0d sig=%h req %0d/%h",
                 k, sel_digit, signals, k % 4, exp_sig());
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      btn_inc = 1'(k % 2);
      tick(1);
    end
    btn_inc = 1'b0;
    tick(10);
    vectors++;
    if ((signals & 32'h7F7F7F7F) !== 32'h40404040 || signals !== exp_sig()) begin
      miscompares++;
      $display("FAIL bounce sig=%h req digits 0 (%h)", signals, exp_sig());
    end
  endtask

  task automatic test_inc_dec_next();
    do_reset();
    btn_inc = 1'b1; btn_dec = 1'b1;
    tick(8);
    btn_inc = 1'b0; btn_dec = 1'b0;
    tick(8);
    vectors++;
    if ((signals & 32'h7F7F7F7F) !== 32'h40404040) begin
      miscompares++;
      $display("FAIL inc_dec_same sig=%h req digits 0", signals);
    end
    for (int k = 0; k < 3; k++) press(0, 7, 7);
    btn_next = 1'b1; btn_inc = 1'b1;
    tick(8);
    btn_next = 1'b0; btn_inc = 1'b0;
    tick(8);
    vectors++;
    if (sel_digit !== 2'd0 || signals[30:24] !== 7'h79 ||
        (signals & 32'h007F7F7F) !== 32'h00404040) begin
      miscompares++;
      $display("FAIL next_inc sel=%0d sig=%h req 0/x79 in byte3",
               sel_digit, signals);
    end
  endtask

  task automatic test_reset_mid_debounce();
    do_reset();
    btn_next = 1'b1;
    tick(4);
    rst = 1'b1;
    model_reset();
    tick(1);
    rst = 1'b0;
    btn_next = 1'b0;
    tick(12);
    vectors++;
    if (sel_digit !== 2'd0 || signals !== exp_sig()) begin
      miscompares++;
      $display("FAIL rst_mid_deb sel=%0d sig=%h req 0/%h",
               sel_digit, signals, exp_sig());
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int s = 0; s < 150; s++) begin
      btn_next = 1'($urandom_range(0, 3) == 0);
      btn_inc  = 1'($urandom_range(0, 1));
      btn_dec  = 1'($urandom_range(0, 2) == 0);
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        tick(1);
        vectors++;
        if (signals !== exp_sig() || sel_digit !== 2'(m_sel)) begin
          miscompares++;
          $display("FAIL random s%0d sig=%h sel=%0d req %h/%0d",
                   s, signals, sel_digit, exp_sig(), m_sel);
        end
      end
    end
    btn_next = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (signals !== 32'hC0C0C0C0 || sel_digit !== 2'd0) begin
      miscompares++;
      $display("FAIL por sig=%h sel=%0d req C0C0C0C0/0", signals, sel_digit);
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_idle_blink();
    test_inc_hold();
    test_dec_next();
    test_bounce();
    test_inc_dec_next();
    test_reset_mid_debounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
